// File: rtl/blink_round_ctrl.sv
// Blink round sequencer: target LED, shrinking response window, score and win/lose; optional lives via BLINK_LIVES_EN.
// Button-to-transition latency 3 edges; no flow control, since the button is the only pacing input.
module blink_round_ctrl #(
  parameter int TICK_DIV    = 25_000_000,
  parameter int BASE_WINDOW = 8,
  parameter int MIN_WINDOW  = 2,
  parameter int WIN_SCORE   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] led,
  output logic [3:0]  score,
  output logic        win,
  output logic        lose,
  output logic        game_over,
  output logic [1:0]  lives
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_HIT, S_MISS, S_WIN, S_LOSE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      win_cnt_q, win_cnt_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            sync1_q, sync2_q, sync3_q;
  logic            btn_rise_q, btn_rise_d;
  logic [15:0]     led_q, led_d;
  logic [3:0]      score_q, score_d;
  logic            tick;
  logic signed [8:0] win_raw;
  logic [7:0]      window_len;
`ifdef BLINK_LIVES_EN
  logic [1:0]      lives_q, lives_d;
`endif

  assign tick       = (presc_q == PRESC_MAX);
  assign btn_rise_d = sync2_q & ~sync3_q;
  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Signed so a score above BASE_WINDOW clamps to the floor instead of wrapping.
  always_comb begin
    win_raw    = $signed(9'(BASE_WINDOW)) - $signed({5'b0, score_q});
    window_len = (win_raw < $signed(9'(MIN_WINDOW))) ? 8'(MIN_WINDOW) : win_raw[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      win_cnt_q  <= '0;
      lfsr_q     <= 16'hACE1;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      btn_rise_q <= 1'b0;
      led_q      <= '0;
      score_q    <= '0;
`ifdef BLINK_LIVES_EN
      lives_q    <= 2'd3;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      win_cnt_q  <= win_cnt_d;
      lfsr_q     <= lfsr_d;
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      btn_rise_q <= btn_rise_d;
      led_q      <= led_d;
      score_q    <= score_d;
`ifdef BLINK_LIVES_EN
      lives_q    <= lives_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (btn_rise_q) state_d = S_ARM;
      S_ARM:  state_d = S_WAIT;
      S_WAIT: begin
        // A press on the final tick takes precedence over the timeout.
        if (btn_rise_q)                      state_d = (sw == led_q) ? S_HIT : S_MISS;
        else if (tick && win_cnt_q == 8'd1)  state_d = S_MISS;
      end
      S_HIT:  state_d = (4'(score_q + 4'd1) == 4'(WIN_SCORE)) ? S_WIN : S_ARM;
`ifdef BLINK_LIVES_EN
      S_MISS: state_d = (lives_q == 2'd1) ? S_LOSE : S_ARM;
`else
      S_MISS: state_d = S_LOSE;
`endif
      S_WIN:  state_d = S_WIN;
      S_LOSE: state_d = S_LOSE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    presc_d   = (state_d != state_q || tick) ? '0 : presc_q + PW'(1);
    win_cnt_d = win_cnt_q;
    led_d     = '0;
    score_d   = score_q;
`ifdef BLINK_LIVES_EN
    lives_d   = lives_q;
`endif
    case (state_q)
      S_ARM: begin
        led_d     = 16'h0001 << lfsr_q[3:0];
        win_cnt_d = window_len;
      end
      S_WAIT: begin
        led_d = (state_d == S_MISS) ? '0 : led_q;
        if (tick && !btn_rise_q && win_cnt_q != 8'd1) win_cnt_d = win_cnt_q - 8'd1;
      end
      S_HIT: begin
        led_d   = (state_d == S_WIN) ? '0 : led_q;
        score_d = score_q + 4'd1;
      end
`ifdef BLINK_LIVES_EN
      S_MISS: lives_d = lives_q - 2'd1;
`endif
      default: led_d = '0;
    endcase
  end

  assign led       = led_q;
  assign score     = score_q;
  assign win       = (state_q == S_WIN);
  assign lose      = (state_q == S_LOSE);
  assign game_over = (state_q == S_WIN) | (state_q == S_LOSE);
`ifdef BLINK_LIVES_EN
  assign lives     = lives_q;
`else
  assign lives     = 2'd1;
`endif

endmodule

// File: tb/tb_blink_round_ctrl.sv
// Directed bench for blink_round_ctrl with a target-LED scoreboard fed by an LFSR reference.
module tb_blink_round_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw;
  logic        btn;
  logic [15:0] led;
  logic [3:0]  score;
  logic        win, lose, game_over;
  logic [1:0]  lives;

  int checks = 0;
  int errors = 0;
  logic [15:0] tb_lfsr;
  logic [15:0] exp_q[$];
  logic [15:0] last_exp;

`ifdef BLINK_LIVES_EN
  localparam logic [1:0] EXP_LIVES = 2'd3;
`else
  localparam logic [1:0] EXP_LIVES = 2'd1;
`endif

  blink_round_ctrl #(
    .TICK_DIV(4), .BASE_WINDOW(8), .MIN_WINDOW(2), .WIN_SCORE(3)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .btn(btn), .led(led), .score(score),
    .win(win), .lose(lose), .game_over(game_over), .lives(lives)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
  always @(posedge clk) begin
    if (!reset) tb_lfsr <= 16'hACE1;
    else        tb_lfsr <= {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called during the ARM cycle: the target is the current LFSR low nibble.
  task automatic push_exp();
    logic [15:0] one;
    one = 16'h0001;
    exp_q.push_back(one << tb_lfsr[3:0]);
  endtask

  task automatic pop_cmp(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, led);
    end else begin
      last_exp = exp_q.pop_front();
      chk(tag, led, last_exp);
    end
  endtask

  // Starts at a negedge; returns 3.5 cycles after the first sampling edge.
  task automatic press();
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic btn_level);
    reset = 1'b0;
    btn   = btn_level;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    btn   = 1'b0;
  endtask

  task automatic start_game();
    sw = 16'h0;
    press();
    push_exp();
    @(negedge clk);
    pop_cmp("start_led");
  endtask

  task automatic hit(input logic [3:0] new_score);
    sw = led;
    press();
    @(negedge clk);
    chk("hit_score", {12'h0, score}, {12'h0, new_score});
    push_exp();
    @(negedge clk);
    pop_cmp("next_led");
  endtask

  task automatic timeout(input int window, input logic [3:0] s);
    repeat (window * 4 - 1) @(negedge clk);
    chk("to_still_wait", led, last_exp);
    @(negedge clk);
    chk("to_miss_led", led, 16'h0);
    chk("to_miss_lose", {15'h0, lose}, 16'h0);
    @(negedge clk);
    chk("to_lose", {15'h0, lose}, 16'h1);
    chk("to_score", {12'h0, score}, {12'h0, s});
  endtask

  initial begin
    reset = 1'b0;
    btn   = 1'b0;
    sw    = 16'h0;
    last_exp = 16'h0;

    // Reset held with the button down.
    do_reset(1'b1);
    chk("rst_led", led, 16'h0);
    chk("rst_score", {12'h0, score}, 16'h0);
    chk("rst_win", {15'h0, win}, 16'h0);
    chk("rst_lose", {15'h0, lose}, 16'h0);
    chk("rst_game_over", {15'h0, game_over}, 16'h0);
    chk("rst_lives", {14'h0, lives}, {14'h0, EXP_LIVES});
    repeat (8) @(negedge clk);
    chk("idle_led", led, 16'h0);

    // Three hits in a row win.
    start_game();
    hit(4'd1);
    hit(4'd2);
    sw = led;
    press();
    @(negedge clk);
    chk("win_score", {12'h0, score}, 16'h3);
    chk("win_win", {15'h0, win}, 16'h1);
    chk("win_game_over", {15'h0, game_over}, 16'h1);
    chk("win_led", led, 16'h0);
    chk("win_lose", {15'h0, lose}, 16'h0);
    press();
    repeat (3) @(negedge clk);
    chk("win_hold_win", {15'h0, win}, 16'h1);
    chk("win_hold_score", {12'h0, score}, 16'h3);
    chk("win_hold_led", led, 16'h0);

    // Wrong switch setting.
    do_reset(1'b0);
    start_game();
    sw = led ^ 16'h0001;
    press();
    chk("miss_led", led, 16'h0);
    chk("miss_lose_early", {15'h0, lose}, 16'h0);
    @(negedge clk);
    chk("miss_lose", {15'h0, lose}, 16'h1);
    chk("miss_game_over", {15'h0, game_over}, 16'h1);
    chk("miss_score", {12'h0, score}, 16'h0);

    // Timeout at score 0: 8 ticks of 4 cycles.
    do_reset(1'b0);
    start_game();
    timeout(8, 4'd0);

    // Timeout at score 2: 6 ticks.
    do_reset(1'b0);
    start_game();
    hit(4'd1);
    hit(4'd2);
    timeout(6, 4'd2);

    // Correct press whose btn_rise coincides with the final tick.
    do_reset(1'b0);
    start_game();
    sw = led;
    repeat (28) @(negedge clk);
    press();
    @(negedge clk);
    chk("final_tick_score", {12'h0, score}, 16'h1);
    chk("final_tick_lose", {15'h0, lose}, 16'h0);
    push_exp();
    @(negedge clk);
    pop_cmp("final_tick_next_led");

    // Reset asserted during WAIT.
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_led", led, 16'h0);
    chk("midrst_score", {12'h0, score}, 16'h0);
    chk("midrst_win", {15'h0, win}, 16'h0);
    chk("midrst_lose", {15'h0, lose}, 16'h0);
    chk("midrst_game_over", {15'h0, game_over}, 16'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_round_ctrl.md
# blink_round_ctrl

Round sequencer for the Blink game. It picks a pseudo-random target LED, opens a response window that shrinks as the score rises, and judges the player's switch setting on each button press. It then updates the score and declares win or lose. It replaces the free-running LED pattern and score bookkeeping with one timed controller. Its `led`, `score`, `win` and `game_over` outputs feed the existing seven-segment, banner and output-mux logic directly.

## Interface
Parameters:
- `TICK_DIV`, default 25_000_000: `clk` cycles per game tick; minimum 2.
- `BASE_WINDOW`, default 8: response window in ticks at score 0; range 2..255.
- `MIN_WINDOW`, default 2: floor on the window in ticks; range 1..`BASE_WINDOW`.
- `WIN_SCORE`, default 15: score that ends the game as a win; range 1..15.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `sw`  in  16  player switches; used as-is, no synchronizer.
- `btn`  in  1  asynchronous player button; synchronized and edge-detected internally.
- `led`  out  16  target pattern; one-hot while a round is open, otherwise 0.
- `score`  out  4  current score, binary.
- `win`  out  1  high in the WIN state.
- `lose`  out  1  high in the LOSE state.
- `game_over`  out  1  equals `win | lose`.
- `lives`  out  2  lives remaining; constant 1 when `BLINK_LIVES_EN` is undefined.

## Operation
- **Tick prescaler:** counts 0..`TICK_DIV`-1 and pulses `tick` for one cycle at terminal count. It is cleared on every state entry, so a window always lasts the full number of ticks.
- **Button path:** a 2-flop synchronizer feeds an edge register. `btn_rise` is a one-cycle pulse on the synchronized 0→1 transition only; holding the button does not repeat it.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1. It steps every `clk` cycle in every state except reset, so the round sequence depends on player timing. The next target is `1 << lfsr[3:0]`.
- **Window length:** `max(BASE_WINDOW - score, MIN_WINDOW)` ticks. Compute it with 9-bit signed arithmetic so it cannot underflow.
- **States:**
  - IDLE: `led`=0. `btn_rise` → ARM.
  - ARM (1 cycle): latch the target into `led`, load the window counter, clear the prescaler → WAIT.
  - WAIT:
    - `btn_rise` with `sw == led` → HIT.
    - `btn_rise` with `sw != led` → MISS.
    - `tick` with window counter == 1 and no `btn_rise` → MISS.
    - `tick` otherwise → decrement the window counter.
    - `btn_rise` and the final `tick` in the same cycle → the button wins.
  - HIT (1 cycle): `score` += 1. If the new score equals `WIN_SCORE` → WIN, else → ARM.
  - MISS (1 cycle): `led`=0 → LOSE. With `BLINK_LIVES_EN`, see Configuration.
  - WIN / LOSE: terminal. `led`=0, `score` held, and `btn` is ignored. Only reset leaves these states.
- **Score:** 4 bits and never wraps, because the game ends at `WIN_SCORE` ≤ 15.
- **Outputs:** all registered. `win`, `lose` and `game_over` are decoded from the state register.

## Timing
- **Reset** (`reset`=0 at an edge) results after that edge:
  - state IDLE;
  - `led`=0, `score`=0, `win`=0, `lose`=0, `game_over`=0;
  - `lives`=3 with `BLINK_LIVES_EN`, else 1;
  - LFSR=16'hACE1, prescaler=0, synchronizer flops=0.
- **Reset mid-round:** takes priority over every transition. The round is abandoned with no score change beyond the reset values.
- **Button latency:** `btn` first sampled high at edge N gives `btn_rise` high during cycle N+2→N+3. The state transition happens at edge N+3.
- **Start latency:** IDLE → ARM at edge N+3, then WAIT with `led` valid from edge N+4.
- **Judgement latency:** HIT or MISS is entered at the edge that consumes `btn_rise`. `score` updates one edge later. The next `led` target is valid two edges after HIT.
- **Window timeout:** WAIT lasts exactly window×`TICK_DIV` cycles when there is no press.
- **Switch sampling:** `sw` is compared in the same cycle `btn_rise` is high. The player must hold `sw` stable across the press.

## Configuration
- **`BLINK_LIVES_EN` defined:**
  - A 2-bit life counter is added, reset value 3.
  - MISS decrements it. If the result is 0 → LOSE, else → ARM with a new target and no score change.
  - `lives` reports the counter.
- **`BLINK_LIVES_EN` undefined:**
  - No life counter. The first MISS → LOSE.
  - `lives` is tied to 1.

## Test plan
Run with `TICK_DIV`=4, `BASE_WINDOW`=8, `MIN_WINDOW`=2, `WIN_SCORE`=3.
- **Reset values:** hold `reset`=0 for 3 cycles, then release → `led`=0, `score`=0, `win`=`lose`=`game_over`=0, state IDLE. Verify `btn` held high through reset does not start a game.
- **Start and HIT:** press `btn` → `led` one-hot at edge N+4. Set `sw=led` and press → `score`=1 one edge after HIT, then a new one-hot `led`.
- **Win:** score 3 HITs in a row → `win`=1, `game_over`=1, `led`=0, `score`=3. Further presses change nothing.
- **Wrong switch:** `sw=led^16'h0001`, then press → `lose`=1, `score` unchanged. With `BLINK_LIVES_EN`: `lives` 3→2, new round, `lose`=0.
- **Timeout:** no press at score 0 → MISS exactly 32 cycles after WAIT entry. At score 2 the window is 6 ticks = 24 cycles.
- **Press on final tick:** correct press coincident with the last tick → HIT, not MISS. Reset asserted during WAIT → all outputs return to their reset values at the next edge.
